// File: rtl/mem_responder.sv
// Default data-memory target: word-addressed RAM behind a one-pulse request/response
// handshake with fixed latency, byte-strobed writes and sticky error flags.
`timescale 1ns/1ps
module mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_enable,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        response_enable,
  output logic [31:0] data,
  output logic        busy,
  output logic        err_range,
  output logic        err_overlap
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic MEMREQ_WRITE = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  in_range_q;
  logic                  err_range_q, err_overlap_q;
  logic                  accept;
  logic                  in_range;

  logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];

  // Byte-offset bits never select anything: the block only returns whole words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign in_range = (addr[31:ADDR_WIDTH+2] == '0);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (request_enable) begin
          accept  = 1'b1;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      in_range_q    <= 1'b0;
      err_range_q   <= 1'b0;
      err_overlap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mode_q     <= mode;
        idx_q      <= addr[ADDR_WIDTH+1:2];
        wdata_q    <= wdata;
        wstrb_q    <= wstrb;
        in_range_q <= in_range;
      end
      if (accept && !in_range) err_range_q <= 1'b1;
      if (request_enable && state_q != IDLE) err_overlap_q <= 1'b1;
    end
  end

  // NOTE: the RAM has no reset; contents survive rst and a write commits only at the edge ending RESP.
  always_ff @(posedge clk) begin
    if (state_q == RESP && mode_q == MEMREQ_WRITE && in_range_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign response_enable = (state_q == RESP);
  assign busy            = (state_q != IDLE);
  assign err_range       = err_range_q;
  assign err_overlap     = err_overlap_q;
  assign data = (state_q == RESP && mode_q != MEMREQ_WRITE && in_range_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 1, 2, 3) share stimulus;
// the ones not under test are held in reset.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst1, rst2, rst3;
  logic        req, mode;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic        resp1, busy1, erng1, eovl1;
  logic        resp2, busy2, erng2, eovl2;
  logic        resp3, busy3, erng3, eovl3;
  logic [31:0] data1, data2, data3;

  logic        cur_resp, cur_busy, cur_erng, cur_eovl;
  logic [31:0] cur_data;

  int sel;
  int lat;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .request_enable(req), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp1), .data(data1),
    .busy(busy1), .err_range(erng1), .err_overlap(eovl1));

  mem_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst2), .request_enable(req), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp2), .data(data2),
    .busy(busy2), .err_range(erng2), .err_overlap(eovl2));

  mem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .request_enable(req), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp3), .data(data3),
    .busy(busy3), .err_range(erng3), .err_overlap(eovl3));

  always_comb begin
    case (sel)
      1: begin
        cur_resp = resp1; cur_busy = busy1; cur_erng = erng1; cur_eovl = eovl1; cur_data = data1;
      end
      3: begin
        cur_resp = resp3; cur_busy = busy3; cur_erng = erng3; cur_eovl = eovl3; cur_data = data3;
      end
      default: begin
        cur_resp = resp2; cur_busy = busy2; cur_erng = erng2; cur_eovl = eovl2; cur_data = data2;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set now are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle and follow it to the cycle after its response.
  task automatic transact(input logic m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] exp, input string tag);
    mode = m; addr = a; wdata = wd; wstrb = ws; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 1; i < lat; i++) begin
      check({tag, "/busy_wait"}, 32'(cur_busy), 32'd1);
      check({tag, "/early_resp"}, 32'(cur_resp), 32'd0);
      tick();
    end
    check({tag, "/resp"}, 32'(cur_resp), 32'd1);
    check({tag, "/busy_resp"}, 32'(cur_busy), 32'd1);
    check({tag, "/data"}, cur_data, exp);
    tick();
    check({tag, "/resp_done"}, 32'(cur_resp), 32'd0);
    check({tag, "/busy_done"}, 32'(cur_busy), 32'd0);
    check({tag, "/data_idle"}, cur_data, 32'd0);
  endtask

  initial begin
    req = 1'b0; mode = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    sel = 2; lat = 2;
    tick();
    tick();

    check("rst/resp", 32'(cur_resp), 32'd0);
    check("rst/data", cur_data, 32'd0);
    check("rst/busy", 32'(cur_busy), 32'd0);
    check("rst/err_range", 32'(cur_erng), 32'd0);
    check("rst/err_overlap", 32'(cur_eovl), 32'd0);
    rst2 = 1'b0;

    // Full-word write then read-back, LATENCY=2.
    transact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, "wr10");
    transact(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, "rd10");

    // Byte strobes: top lane only, then an all-zero strobe.
    transact(1'b1, 32'h13, 32'h11000000, 4'b1000, 32'h0, "wr13_lane3");
    transact(1'b0, 32'h10, 32'h0, 4'b0000, 32'h11ADBEEF, "rd10_lane3");
    transact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, "wr10_nostrb");
    transact(1'b0, 32'h10, 32'h0, 4'b0000, 32'h11ADBEEF, "rd10_nostrb");

    // Range: 0x4000 would alias word 0 if its upper bits were not checked.
    check("range/err_before", 32'(cur_erng), 32'd0);
    transact(1'b1, 32'h0, 32'hA5A50001, 4'b1111, 32'h0, "wr0");
    transact(1'b0, 32'h00004000, 32'h0, 4'b0000, 32'h0, "rd4000");
    check("range/err_after", 32'(cur_erng), 32'd1);
    transact(1'b1, 32'h00004000, 32'hFFFFFFFF, 4'b1111, 32'h0, "wr4000");
    transact(1'b0, 32'h0, 32'h0, 4'b0000, 32'hA5A50001, "rd0_after_oor");

    // Overlap: second pulse one cycle after the first must be ignored.
    check("ovl/err_before", 32'(cur_eovl), 32'd0);
    mode = 1'b0; addr = 32'h10; req = 1'b1;
    tick();
    addr = 32'h0;
    check("ovl/busy", 32'(cur_busy), 32'd1);
    tick();
    req = 1'b0;
    check("ovl/resp", 32'(cur_resp), 32'd1);
    check("ovl/data", cur_data, 32'h11ADBEEF);
    tick();
    check("ovl/resp_done", 32'(cur_resp), 32'd0);
    tick();
    check("ovl/no_second_resp", 32'(cur_resp), 32'd0);
    check("ovl/busy_idle", 32'(cur_busy), 32'd0);
    check("ovl/err_after", 32'(cur_eovl), 32'd1);
    check("ovl/err_range_sticky", 32'(cur_erng), 32'd1);

    // Reset in the middle of a write, LATENCY=3.
    rst2 = 1'b1;
    sel = 3; lat = 3;
    rst3 = 1'b0;
    transact(1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 32'h0, "wr20_base");
    mode = 1'b1; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'b1111; req = 1'b1;
    tick();
    req = 1'b0;
    check("rstmid/busy_before", 32'(cur_busy), 32'd1);
    rst3 = 1'b1;
    #1;
    check("rstmid/resp", 32'(cur_resp), 32'd0);
    check("rstmid/busy", 32'(cur_busy), 32'd0);
    check("rstmid/data", cur_data, 32'd0);
    check("rstmid/err_range", 32'(cur_erng), 32'd0);
    check("rstmid/err_overlap", 32'(cur_eovl), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid/no_resp", 32'(cur_resp), 32'd0);
    end
    rst3 = 1'b0;
    transact(1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, "rd20_after_rst");

    // LATENCY=1: alternating write/read every two cycles.
    rst3 = 1'b1;
    sel = 1; lat = 1;
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, v;
      a = 32'h40 + 32'(4 * i);
      v = 32'h01020304 * 32'(i + 1) ^ 32'h5A000000;
      transact(1'b1, a, v, 4'b1111, 32'h0, "l1_wr");
      transact(1'b0, a, 32'h0, 4'b0000, v, "l1_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
